// File: rtl/seq_multiplier_pkg.sv
// Shared state encodings and default operand width for the sequential multiplier.
package seq_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_step.sv
// One radix-2 shift-add step: conditionally add the multiplicand into the upper
// half of the accumulator, then shift the whole {hi, lo} pair right by one bit.
module mul_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH:0] sum;

  // The extra sum bit holds the carry so the shifted result never overflows.
  always_comb begin
    sum     = {1'b0, acc_hi} + ({1'b0, mcand} & {(WIDTH+1){acc_lo[0]}});
    next_hi = sum[WIDTH:1];
    next_lo = {sum[0], acc_lo[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential radix-2 shift-add multiplier, one product per WIDTH+2 cycles.
// Define SEQ_MUL_SIGNED_EN to honour sgn (two's-complement operands).
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] m
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] m_next;
  logic               last_step;

  assign last_step = (cnt == CW'(1));
  assign product   = {step_hi, step_lo};

`ifdef SEQ_MUL_SIGNED_EN
  logic neg;
  logic neg_q;

  // Work on magnitudes; the sign is reapplied once when the product lands in m.
  always_comb begin
    a_mag = (sgn && a[WIDTH-1]) ? -a : a;
    b_mag = (sgn && b[WIDTH-1]) ? -b : b;
    neg   = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst)
      neg_q <= 1'b0;
    else if (state == IDLE && in_valid)
      neg_q <= neg;
  end

  assign m_next = neg_q ? -product : product;
`else
  logic unused_sgn;

  assign unused_sgn = sgn;
  assign a_mag      = a;
  assign b_mag      = b;
  assign m_next     = product;
`endif

  mul_step #(.WIDTH(WIDTH)) u_step (
    .mcand   (mcand),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_next = RUN;
      end
      RUN: begin
        if (last_step)
          state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // m only changes on entry to DONE, so it is stable for the whole handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      m      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= a_mag;
            acc_hi <= '0;
            acc_lo <= b_mag;
            cnt    <= CW'(WIDTH);
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt - CW'(1);
          if (last_step)
            m <= m_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH=16; expectations follow
// SEQ_MUL_SIGNED_EN so the same bench covers both builds.
module tb_seq_multiplier;

  localparam int W = 16;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           sgn;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] m;

  int tests;
  int fails;
  int cyc;
  int accept_cyc;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sgn;
    logic [2*W-1:0] exp_u;
    logic [2*W-1:0] exp_s;
  } vec_t;

  vec_t vecs[10];

  seq_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sgn       (sgn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .m         (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    longint p;
    p = longint'({16'b0, x}) * longint'({16'b0, y});
`ifdef SEQ_MUL_SIGNED_EN
    if (s)
      p = longint'($signed(x)) * longint'($signed(y));
`else
    if (s)
      p = p;
`endif
    return p[2*W-1:0];
  endfunction

  // One full transaction with out_ready held high: accept, wait, check, handshake.
  task automatic apply_stimulus(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                                input logic [2*W-1:0] exp_m, input string name);
    int n;
    a = ia;
    b = ib;
    sgn = is;
    out_ready = 1'b1;
    in_valid = 1'b1;
    check_output({name, " ready"}, 64'(in_ready), 64'd1);
    tick();
    accept_cyc = cyc;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check_output({name, " latency"}, 64'(n), 64'd16);
    check_output({name, " m"}, 64'(m), 64'(exp_m));
    tick();
    check_output({name, " idle"}, 64'({in_ready, out_valid}), 64'b10);
  endtask

  initial begin
    int n;
    int prev;
    bit seen;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic           rs;

    tests = 0;
    fails = 0;
    vecs[0] = '{16'd3,    16'd5,    1'b0, 32'h0000000F, 32'h0000000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 32'hFFFE0001};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE0001, 32'h00000001};
    vecs[3] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000, 32'h40000000};
    vecs[4] = '{16'hFFFD, 16'd7,    1'b1, 32'h0006FFEB, 32'hFFFFFFEB};
    vecs[5] = '{16'd0,    16'h1234, 1'b0, 32'h00000000, 32'h00000000};
    vecs[6] = '{16'h1234, 16'h0010, 1'b0, 32'h00012340, 32'h00012340};
    vecs[7] = '{16'hFFFF, 16'd1,    1'b1, 32'h0000FFFF, 32'hFFFFFFFF};
    vecs[8] = '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001, 32'h3FFF0001};
    vecs[9] = '{16'd100,  16'd200,  1'b0, 32'h00004E20, 32'h00004E20};

    // Reset with in_valid asserted: reset must win.
    rst = 1'b1;
    in_valid = 1'b1;
    a = 16'd9;
    b = 16'd9;
    sgn = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check_output("reset in_ready", 64'(in_ready), 64'd1);
    check_output("reset out_valid", 64'(out_valid), 64'd0);
    check_output("reset m", 64'(m), 64'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
`ifdef SEQ_MUL_SIGNED_EN
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp_s, $sformatf("vec%0d", i));
`else
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp_u, $sformatf("vec%0d", i));
`endif
    end

    // Back-pressure in DONE with stray in_valid pulses throughout.
    a = 16'd6;
    b = 16'd7;
    sgn = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      in_valid = (n % 3 == 0);
      a = 16'd9;
      b = 16'd9;
      tick();
      n++;
    end
    check_output("hold latency", 64'(n), 64'd16);
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      tick();
      check_output($sformatf("hold out_valid %0d", k), 64'(out_valid), 64'd1);
      check_output($sformatf("hold m %0d", k), 64'(m), 64'h2A);
      check_output($sformatf("hold in_ready %0d", k), 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check_output("hold release", 64'({in_ready, out_valid}), 64'b10);
    tick();
    check_output("hold no capture", 64'(in_ready), 64'd1);

    // Reset in the middle of RUN aborts the product.
    a = 16'd100;
    b = 16'd200;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("abort in_ready", 64'(in_ready), 64'd1);
    check_output("abort out_valid", 64'(out_valid), 64'd0);
    check_output("abort m", 64'(m), 64'd0);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (out_valid)
        seen = 1'b1;
    end
    check_output("abort no product", 64'(seen), 64'd0);
    apply_stimulus(16'd2, 16'd4, 1'b0, 32'd8, "after abort");

    // Back-to-back random traffic, checked against the arithmetic model.
    prev = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      apply_stimulus(ra, rb, rs, ref_mul(ra, rb, rs), $sformatf("rand%0d", i));
      if (i > 0)
        check_output($sformatf("rand%0d spacing", i), 64'(accept_cyc - prev), 64'(W + 2));
      prev = accept_cyc;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits (legal range 4..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  WIDTH  multiplicand.
REQ-007 SHALL have port b  input  WIDTH  multiplier.
REQ-008 SHALL have port sgn  input  1  1 = two's-complement operands, 0 = unsigned; sampled with a and b.
REQ-009 SHALL have port out_valid  output  1  product m is valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes the product.
REQ-011 SHALL have port m  output  2*WIDTH  product.

Function
REQ-012 SHALL implement states IDLE, RUN and DONE.
REQ-013 In IDLE: in_ready=1 and out_valid=0.
REQ-014 In IDLE with in_valid=1: capture a, b and sgn; load the bit counter with WIDTH; go to RUN.
REQ-015 In RUN: in_ready=0; each cycle perform one radix-2 shift-add step on the lowest remaining multiplier bit and decrement the counter.
REQ-016 Leave RUN for DONE on the edge where the counter reaches 0, so out_valid rises exactly WIDTH cycles after the accept edge.
REQ-017 In DONE: out_valid=1, in_ready=0; m stays stable until out_valid=1 and out_ready=1, then return to IDLE on that edge.
REQ-018 Any in_valid while in RUN or DONE SHALL be ignored, with no capture and no state change.
REQ-019 m SHALL be the exact product: no truncation, no overflow. Example: unsigned max*max = 2^(2W) - 2^(W+1) + 1.
REQ-020 Back-to-back operation: a new accept is possible in the cycle after the DONE-to-IDLE handshake, giving a minimum throughput of one product per WIDTH+2 cycles.
REQ-021 m SHALL hold its last value outside DONE; its value there is don't-care for consumers.

Reset
REQ-022 While rst=1, the next state SHALL be IDLE, counter=0, m=0, out_valid=0 and in_ready=1 (in_ready visible after the edge).
REQ-023 rst during RUN or DONE SHALL abort the operation; no product is delivered and no partial state survives.
REQ-024 rst has priority over in_valid and out_ready on the same edge.

Configuration
REQ-025 Macro SEQ_MUL_SIGNED_EN defined: sgn=1 SHALL multiply in two's complement. Operand magnitudes are taken at capture and the result is negated on entry to DONE when the operand signs differ. The WIDTH-cycle latency is unchanged.
REQ-026 Macro SEQ_MUL_SIGNED_EN undefined: sgn SHALL be ignored, all operands treated as unsigned, and the sign logic removed from the netlist.

Structure
REQ-027 A shared package/header SHALL hold the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-028 The bit counter width SHALL be $clog2(WIDTH)+1.
REQ-029 The single sub-module shall be mul_step: a combinational one-bit shift-add datapath with a WIDTH parameter, instantiated once; the FSM stays in seq_multiplier.

Verification (WIDTH=16)
REQ-030 Scenario: a=3, b=5, sgn=0, out_ready=1 -> out_valid rises 16 cycles after accept, m=0x0000000F, back in IDLE next cycle.
REQ-031 Scenario: a=0xFFFF, b=0xFFFF, sgn=0 -> m=0xFFFE0001. With signed build and sgn=1 -> m=0x00000001.
REQ-032 Scenario (signed build): a=0x8000, b=0x8000, sgn=1 -> m=0x40000000; a=0xFFFD (-3), b=7 -> m=0xFFFFFFEB.
REQ-033 Scenario: out_ready held 0 for 10 cycles in DONE -> m and out_valid stay stable and in_ready stays 0; in_valid pulses with a=9, b=9 during RUN/DONE have no effect; the first product is delivered unchanged.
REQ-034 Scenario: rst=1 for one cycle at RUN cycle 7 of a=100, b=200 -> IDLE, m=0, out_valid never asserted; a following a=2, b=4 yields m=8 after 16 cycles.
REQ-035 Scenario: random a, b, sgn for 1000 back-to-back transactions -> every m matches the reference model, with spacing WIDTH+2 cycles.
